// File: rtl/pulse_serial_deserialiser_pkg.sv
// Shared types and sizing helpers for the pulse-triggered
// serial deserialiser.
package ds_adc_pkg;

  localparam int DEF_WIDTH = 13;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VALID,
    SHIFT
  } state_t;

  // Bits needed to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_serial_deserialiser_if.sv
// Trigger / serial lane / parallel result bundle between the
// deserialiser and its environment.
interface pulse_serial_deserialiser_if #(
  parameter int WIDTH = 13
);
  logic             auto_trig_en;
  logic             trig_req;
  logic             trigger_out;
  logic             serial_in;
  logic             valid_in;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             frame_err;
  logic             timeout;
  logic             busy;

  modport slave (
    input  auto_trig_en,
    input  trig_req,
    input  serial_in,
    input  valid_in,
    output trigger_out,
    output data_out,
    output data_valid,
    output frame_err,
    output timeout,
    output busy
  );

  modport master (
    output auto_trig_en,
    output trig_req,
    output serial_in,
    output valid_in,
    input  trigger_out,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  timeout,
    input  busy
  );
endinterface

// File: rtl/pulse_serial_deserialiser_trig.sv
// Periodic/manual trigger merge; emits a request only while
// the receiver is idle, so busy-time expiries are dropped.
module ds_trig_gen
  import ds_adc_pkg::*;
#(
  parameter int TRIG_PERIOD = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic auto_trig_en,
  input  logic trig_req,
  input  logic idle,
  output logic req
);

  localparam int PW = cnt_w(TRIG_PERIOD);

  logic [PW-1:0] pcnt;
  logic          expire;

  assign expire = auto_trig_en &&
                  (pcnt == PW'(TRIG_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (!auto_trig_en || expire) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  assign req = idle && (trig_req || expire);

endmodule

// File: rtl/pulse_serial_deserialiser.sv
// Receive side of the ADC pulse-triggered serial link: issues
// triggers and rebuilds MSB-first frames into parallel words.
module pulse_serial_deserialiser
  import ds_adc_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int TRIG_PERIOD = 64,
  parameter int TIMEOUT     = 8
) (
  input  logic clk,
  input  logic rst_n,
  pulse_serial_deserialiser_if.slave bus
);

  localparam int BW = cnt_w(WIDTH);
  localparam int TW = cnt_w(TIMEOUT);

  state_t           state, state_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [WIDTH-2:0] sh, sh_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             dv_q, dv_n;
  logic             ferr_q, ferr_n;
  logic             to_q, to_n;
  logic             trig_q, trig_n;
  logic             req;

  ds_trig_gen #(
    .TRIG_PERIOD(TRIG_PERIOD)
  ) u_trig (
    .clk         (clk),
    .rst_n       (rst_n),
    .auto_trig_en(bus.auto_trig_en),
    .trig_req    (bus.trig_req),
    .idle        (state == IDLE),
    .req         (req)
  );

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    tcnt_n  = tcnt;
    sh_n    = sh;
    data_n  = data_q;
    dv_n    = 1'b0;
    ferr_n  = 1'b0;
    to_n    = 1'b0;
    trig_n  = 1'b0;
    unique case (state)
      IDLE: begin
        // An unsolicited frame wins over a trigger request.
        if (bus.valid_in) begin
          sh_n    = (WIDTH-1)'(bus.serial_in);
          bcnt_n  = BW'(1);
          state_n = SHIFT;
        end else if (req) begin
          trig_n  = 1'b1;
          tcnt_n  = '0;
          state_n = WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        if (bus.valid_in) begin
          sh_n    = (WIDTH-1)'(bus.serial_in);
          bcnt_n  = BW'(1);
          state_n = SHIFT;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          to_n    = 1'b1;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      SHIFT: begin
        if (bus.valid_in) begin
          ferr_n = 1'b1;
          sh_n   = (WIDTH-1)'(bus.serial_in);
          bcnt_n = BW'(1);
        end else if (bcnt == BW'(WIDTH - 1)) begin
          data_n  = {sh, bus.serial_in};
          dv_n    = 1'b1;
          bcnt_n  = '0;
          state_n = IDLE;
        end else begin
          sh_n   = {sh[WIDTH-3:0], bus.serial_in};
          bcnt_n = bcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      bcnt   <= '0;
      tcnt   <= '0;
      sh     <= '0;
      data_q <= '0;
      dv_q   <= 1'b0;
      ferr_q <= 1'b0;
      to_q   <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      tcnt   <= tcnt_n;
      sh     <= sh_n;
      data_q <= data_n;
      dv_q   <= dv_n;
      ferr_q <= ferr_n;
      to_q   <= to_n;
      trig_q <= trig_n;
    end
  end

  assign bus.trigger_out = trig_q;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_err   = ferr_q;
  assign bus.timeout     = to_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_pulse_serial_deserialiser.sv
// Directed bench for pulse_serial_deserialiser with
// hand-computed expectations.
module tb_pulse_serial_deserialiser;

  localparam int W = 13;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_trig = 0;
  int   n_dv   = 0;
  int   n_ferr = 0;
  int   n_to   = 0;

  pulse_serial_deserialiser_if #(.WIDTH(W)) bus ();

  pulse_serial_deserialiser #(
    .WIDTH      (W),
    .TRIG_PERIOD(64),
    .TIMEOUT    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.trigger_out) n_trig++;
    if (bus.data_valid)  n_dv++;
    if (bus.frame_err)   n_ferr++;
    if (bus.timeout)     n_to++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives bits w[W-1 .. W-nb]; optional trig_req on bit pb.
  task automatic send_bits(input logic [W-1:0] w,
                           input int nb,
                           input int pb);
    for (int i = 0; i < nb; i++) begin
      bus.valid_in  = (i == 0);
      bus.serial_in = w[W-1-i];
      bus.trig_req  = (i == pb);
      tick();
    end
    bus.valid_in  = 1'b0;
    bus.serial_in = 1'b0;
    bus.trig_req  = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_trig"}, 32'(bus.trigger_out), 0);
    chk({tag, "_dout"}, 32'(bus.data_out), 0);
    chk({tag, "_dv"},   32'(bus.data_valid), 0);
    chk({tag, "_ferr"}, 32'(bus.frame_err), 0);
    chk({tag, "_to"},   32'(bus.timeout), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  int s_dv, s_ferr, s_to, s_trig, t_prev, wt;
  logic [W-1:0] words [3];
  logic seen;

  initial begin
    words[0] = 13'h0555;
    words[1] = 13'h1ABC;
    words[2] = 13'h0F0F;
    rst_n = 1'b0;
    bus.auto_trig_en = 1'b0;
    bus.trig_req     = 1'b0;
    bus.serial_in    = 1'b0;
    bus.valid_in     = 1'b0;
    tick();
    tick();
    chk_idle_outs("rst");
    rst_n = 1'b1;
    tick();

    // Manual trigger, frame 2 cycles after trigger_out.
    s_trig = n_trig; s_dv = n_dv;
    s_ferr = n_ferr; s_to = n_to;
    bus.trig_req = 1'b1;
    tick();
    bus.trig_req = 1'b0;
    chk("man_trig", 32'(bus.trigger_out), 1);
    chk("man_busy", 32'(bus.busy), 1);
    tick();
    tick();
    send_bits(13'h0A5B, W, -1);
    chk("man_dv_early", 32'(n_dv - s_dv), 0);
    chk("man_dv", 32'(bus.data_valid), 1);
    chk("man_dout", 32'(bus.data_out), 32'h0A5B);
    chk("man_busy_end", 32'(bus.busy), 0);
    tick();
    chk("man_dv_one", 32'(bus.data_valid), 0);
    chk("man_ntrig", 32'(n_trig - s_trig), 1);
    chk("man_nferr", 32'(n_ferr - s_ferr), 0);
    chk("man_nto", 32'(n_to - s_to), 0);

    // Trigger with no response -> timeout 8 cycles later.
    s_dv = n_dv;
    bus.trig_req = 1'b1;
    tick();
    bus.trig_req = 1'b0;
    chk("to_trig", 32'(bus.trigger_out), 1);
    for (int i = 0; i < 7; i++) tick();
    chk("to_early", 32'(bus.timeout), 0);
    chk("to_busy_hold", 32'(bus.busy), 1);
    tick();
    chk("to_pulse", 32'(bus.timeout), 1);
    chk("to_busy", 32'(bus.busy), 0);
    chk("to_dout", 32'(bus.data_out), 32'h0A5B);
    tick();
    chk("to_one", 32'(bus.timeout), 0);
    chk("to_ndv", 32'(n_dv - s_dv), 0);

    // Restart at bit 6 of 1FFF, then full 0001.
    s_dv = n_dv; s_ferr = n_ferr;
    send_bits(13'h1FFF, 6, -1);
    send_bits(13'h0001, W, -1);
    chk("fe_dv", 32'(bus.data_valid), 1);
    chk("fe_dout", 32'(bus.data_out), 32'h0001);
    tick();
    chk("fe_nferr", 32'(n_ferr - s_ferr), 1);
    chk("fe_ndv", 32'(n_dv - s_dv), 1);

    // Auto trigger with a responding serialiser.
    s_dv = n_dv; s_trig = n_trig;
    t_prev = 0;
    bus.auto_trig_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      for (int j = 0; j < 100 && !seen; j++) begin
        tick();
        seen = bus.trigger_out;
      end
      chk("auto_seen", 32'(seen), 1);
      if (k > 0) chk("auto_period", 32'(cyc - t_prev), 64);
      t_prev = cyc;
      tick();
      tick();
      send_bits(words[k], W, 5);
      chk("auto_dv", 32'(bus.data_valid), 1);
      chk("auto_dout", 32'(bus.data_out), 32'(words[k]));
    end
    bus.auto_trig_en = 1'b0;
    tick();
    chk("auto_ntrig", 32'(n_trig - s_trig), 3);
    chk("auto_ndv", 32'(n_dv - s_dv), 3);

    // Unsolicited frame from IDLE.
    s_trig = n_trig; s_dv = n_dv;
    for (int i = 0; i < 3; i++) tick();
    send_bits(13'h1000, W, -1);
    chk("uns_dv", 32'(bus.data_valid), 1);
    chk("uns_dout", 32'(bus.data_out), 32'h1000);
    tick();
    chk("uns_ntrig", 32'(n_trig - s_trig), 0);
    chk("uns_ndv", 32'(n_dv - s_dv), 1);

    // Reset at bit 7, then a clean frame.
    send_bits(13'h1555, 7, -1);
    rst_n = 1'b0;
    #1;
    chk_idle_outs("mrst");
    tick();
    tick();
    chk_idle_outs("mrst2");
    rst_n = 1'b1;
    s_trig = n_trig; s_dv = n_dv;
    s_ferr = n_ferr; s_to = n_to;
    for (int i = 0; i < 4; i++) tick();
    chk_idle_outs("post");
    send_bits(13'h0123, W, -1);
    chk("post_ndv0", 32'(n_dv - s_dv), 0);
    chk("post_dv", 32'(bus.data_valid), 1);
    chk("post_dout", 32'(bus.data_out), 32'h0123);
    tick();
    chk("post_ndv", 32'(n_dv - s_dv), 1);
    wt = (n_trig - s_trig) + (n_ferr - s_ferr) + (n_to - s_to);
    chk("post_other", 32'(wt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
